// File: rtl/bytes_to_coords_pkg.sv
// Shared types and constants for the bytes_to_coords_n deframer and its shadow register.
package bytes_to_coords_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    localparam logic [7:0] DEF_START_BYTE = 8'h53;
    localparam logic [7:0] DEF_END_BYTE   = 8'h45;

    localparam int AXIS_X   = 0;
    localparam int AXIS_Y   = 1;
    localparam int AXIS_Z   = 2;
    localparam int NUM_AXES = AXIS_Z + 1;

    // Bits needed to index n distinct values (never less than one).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coord_shift_reg.sv
// Byte-indexed shadow register: byte k of the payload lands in bits [8k +: 8], in wire order.
module coord_shift_reg
    import bytes_to_coords_pkg::*;
#(
    parameter int PB = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic [idx_width(PB)-1:0] idx_i,
    input  logic [7:0]               byte_i,
    output logic [PB*8-1:0]          data_o
);

    localparam int IDX_W = idx_width(PB);

    logic [7:0] bytes_q [PB];

    generate
        for (genvar gi = 0; gi < PB; gi++) begin : g_byte
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    bytes_q[gi] <= 8'h00;
                end else if (clear_i) begin
                    bytes_q[gi] <= 8'h00;
                end else if (load_i && (idx_i == IDX_W'(gi))) begin
                    bytes_q[gi] <= byte_i;
                end
            end
            assign data_o[gi*8 +: 8] = bytes_q[gi];
        end
    endgenerate

endmodule

// File: rtl/bytes_to_coords_n.sv
// Framed byte-stream to NUM_POINTS x (x,y,z) coordinate deframer with timeout.
// Optional payload XOR checksum byte when BYTES_TO_COORDS_CHECKSUM_EN is defined.
module bytes_to_coords_n
    import bytes_to_coords_pkg::*;
#(
    parameter int         NUM_POINTS     = 2,
    parameter int         COORD_WIDTH    = 16,
    parameter logic [7:0] START_BYTE     = DEF_START_BYTE,
    parameter logic [7:0] END_BYTE       = DEF_END_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [7:0]                              data_byte,
    input  logic                                    we,
    output logic                                    ready,
    output logic [NUM_POINTS*NUM_AXES*COORD_WIDTH-1:0] coords,
    output logic                                    frame_error,
    output logic                                    busy
);

    localparam int TOT_W = NUM_POINTS * NUM_AXES * COORD_WIDTH;
    localparam int PB    = TOT_W / 8;
    localparam int BPA   = COORD_WIDTH / 8;
    localparam int CNT_W = idx_width(PB);
    localparam int TO_W  = idx_width(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PB - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic               ready_q, ready_d;
    logic               frame_error_q, frame_error_d;
    logic [TOT_W-1:0]   coords_q, coords_d;
    logic               sh_clear, sh_load;
    logic               timeout_hit;
    logic [TOT_W-1:0]   shadow_bytes;
    logic [TOT_W-1:0]   shadow_coords;
`ifdef BYTES_TO_COORDS_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    coord_shift_reg #(.PB(PB)) u_shadow (
        .clock   (clock),
        .reset   (reset),
        .clear_i (sh_clear),
        .load_i  (sh_load),
        .idx_i   (byte_cnt_q),
        .byte_i  (data_byte),
        .data_o  (shadow_bytes)
    );

    // Wire order is axis-major with each axis MSB byte first; remap to the packed coordinate layout.
    generate
        for (genvar gi = 0; gi < PB; gi++) begin : g_map
            localparam int AX = gi / BPA;
            localparam int BJ = gi % BPA;
            assign shadow_coords[AX*COORD_WIDTH + (BPA-1-BJ)*8 +: 8] = shadow_bytes[gi*8 +: 8];
        end
    endgenerate

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) && !we && (idle_cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        ready_d       = 1'b0;
        frame_error_d = 1'b0;
        coords_d      = coords_q;
        sh_clear      = 1'b0;
        sh_load       = 1'b0;
`ifdef BYTES_TO_COORDS_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        if (state_q == ST_IDLE || we) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (timeout_hit) begin
            state_d       = ST_IDLE;
            frame_error_d = 1'b1;
            idle_cnt_d    = '0;
        end else if (we) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_byte == START_BYTE) begin
                        state_d    = ST_PAYLOAD;
                        byte_cnt_d = '0;
                        sh_clear   = 1'b1;
`ifdef BYTES_TO_COORDS_CHECKSUM_EN
                        csum_d     = 8'h00;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    sh_load    = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef BYTES_TO_COORDS_CHECKSUM_EN
                    csum_d     = csum_q ^ data_byte;
                    if (byte_cnt_q == LAST_IDX) state_d = ST_CHECK;
`else
                    if (byte_cnt_q == LAST_IDX) state_d = ST_TRAILER;
`endif
                end
`ifdef BYTES_TO_COORDS_CHECKSUM_EN
                ST_CHECK: begin
                    if (data_byte == csum_q) begin
                        state_d = ST_TRAILER;
                    end else begin
                        state_d       = ST_IDLE;
                        frame_error_d = 1'b1;
                    end
                end
`endif
                ST_TRAILER: begin
                    if (data_byte == END_BYTE) begin
                        coords_d = shadow_coords;
                        ready_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        // A stray start marker in the trailer slot begins the next frame right away.
                        if (data_byte == START_BYTE) begin
                            state_d    = ST_PAYLOAD;
                            byte_cnt_d = '0;
                            sh_clear   = 1'b1;
`ifdef BYTES_TO_COORDS_CHECKSUM_EN
                            csum_d     = 8'h00;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            ready_q       <= 1'b0;
            frame_error_q <= 1'b0;
            coords_q      <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            ready_q       <= ready_d;
            frame_error_q <= frame_error_d;
            coords_q      <= coords_d;
        end
    end

`ifdef BYTES_TO_COORDS_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign ready       = ready_q;
    assign frame_error = frame_error_q;
    assign coords      = coords_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/bytes_to_coords_n.md
# bytes_to_coords_n

Parametrised successor to the fixed two-point byte deframer. Consumes the serial byte stream from the UART receiver, one byte per `we` strobe, and locates frames delimited by start/end marker bytes. Assembles NUM_POINTS points of three signed COORD_WIDTH-bit axes (x, y, z) and publishes them atomically with a one-cycle `ready` pulse. Adds malformed-frame detection, inter-byte timeout and optional checksum checking, and sits between the UART receiver and the gesture/flight-control logic.

## Interface
- NUM_POINTS, 2: number of points per frame (1..8).
- COORD_WIDTH, 16: bits per axis; must be a multiple of 8 (8..32).
- START_BYTE, 8'h53: frame start marker ('S').
- END_BYTE, 8'h45: frame end marker ('E').
- TIMEOUT_CYCLES, 1000: maximum idle cycles between bytes inside a frame. 0 disables the timeout.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_byte  in  8  received byte; sampled only when `we`=1.
- we  in  1  byte strobe; each rising edge with `we`=1 consumes one byte.
- ready  out  1  one-cycle pulse; a new frame has been committed to `coords`.
- coords  out  NUM_POINTS*3*COORD_WIDTH  packed coordinates. Point p, axis a (x=0, y=1, z=2) occupies bits [(3p+a)*COORD_WIDTH +: COORD_WIDTH].
- frame_error  out  1  one-cycle pulse; a frame was dropped.
- busy  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- Payload length is PB = NUM_POINTS*3*COORD_WIDTH/8 bytes.
- Byte order is point 0 first, then x, y, z within each point. Each axis is sent MSB byte first.
- The payload is collected in a shadow register. `coords` changes only when a frame is committed, so consumers never see partial data.
- IDLE:
  - `we` with START_BYTE goes to PAYLOAD and clears the byte counter.
  - Any other byte is ignored silently.
- PAYLOAD:
  - Each `we` byte is written into the shadow register and the counter increments.
  - After byte PB-1 the FSM goes to CHECK if the checksum is compiled in, otherwise to TRAILER.
  - Marker values inside the payload are treated as data.
- CHECK (checksum build only):
  - The next byte is compared with the XOR of all payload bytes.
  - Match goes to TRAILER.
  - Mismatch pulses `frame_error` and goes to IDLE.
- TRAILER:
  - END_BYTE copies shadow to `coords`, pulses `ready` and goes to IDLE.
  - Any other byte pulses `frame_error` and drops the frame. If that byte equals START_BYTE, the FSM goes directly to PAYLOAD (resync) with the counter cleared; otherwise it goes to IDLE.
- Timeout:
  - Outside IDLE, a counter counts cycles with `we`=0 and clears on every `we`.
  - On reaching TIMEOUT_CYCLES it pulses `frame_error` and returns to IDLE.
- Reset, including mid-frame: state IDLE, counters 0, shadow 0, `coords` 0, `ready` 0, `frame_error` 0, `busy` 0.

## Timing
- All outputs are registered.
- `ready` and the new `coords` value appear in the cycle after the edge that accepts END_BYTE (latency 1). `coords` then holds that value until the next commit.
- `frame_error` is high for exactly one cycle, in the cycle after the offending byte or the timeout expiry.
- Back-to-back `we` on every cycle is supported at full rate. The byte after END_BYTE may be the START_BYTE of the next frame in the immediately following cycle.
- `ready` and `frame_error` are never high in the same cycle.

## Configuration
- `BYTES_TO_COORDS_CHECKSUM_EN` defined:
  - The CHECK state and the XOR accumulator are compiled in.
  - Frame length on the wire is 1 + PB + 1 + 1 bytes.
- Not defined:
  - No CHECK state and no accumulator.
  - Frame length on the wire is 1 + PB + 1 bytes.

## Structure
- Shared package `bytes_to_coords_pkg`:
  - FSM state enum (IDLE, PAYLOAD, CHECK, TRAILER).
  - Default START_BYTE and END_BYTE constants.
  - Axis index constants AXIS_X, AXIS_Y, AXIS_Z.
- One sub-module, `coord_shift_reg`: a byte-indexed shadow register with load enable and clear, parametrised by PB.
- FSM, timeout counter and checksum logic stay in the top module.

## Test plan
All scenarios use the defaults (NUM_POINTS=2, COORD_WIDTH=16, TIMEOUT_CYCLES=1000) unless stated.
- Nominal frame: send 53, 00 01 00 02 00 03 00 04 00 05 00 06, 45 with one-cycle `we` pulses.
  - Required: single `ready` pulse one cycle after 45.
  - Required: axes read 1,2,3,4,5,6, i.e. `coords`=96'h0006_0005_0004_0003_0002_0001.
- Garbage and resync: send 32 10 before the nominal frame, then 53 + 12 bytes + 53 + 12 bytes + 45.
  - Required: garbage ignored.
  - Required: first trailer gives one `frame_error`, then `ready` for the second frame's payload.
- Bad trailer: nominal frame ending in 46 instead of 45.
  - Required: `frame_error` pulse, no `ready`, `coords` unchanged from the previous frame.
- Timeout: send 53 and 4 payload bytes, then hold `we`=0 for 1000 cycles.
  - Required: `frame_error` pulse and `busy` low.
  - Required: a following nominal frame commits correctly.
- Reset mid-frame: assert `reset` after 6 payload bytes.
  - Required: `coords`=0, `busy`=0, no pulses.
  - Required: the next nominal frame commits correctly.
- With `BYTES_TO_COORDS_CHECKSUM_EN`: nominal payload, checksum 07, then 45.
  - Required: `ready`.
  - Repeat with checksum 08: `frame_error`, no `ready`.
